cic_int_n5: RTL and testbench

- Five-stage interpolating CIC filter, differential delay 2, rate 12; transmit-side counterpart of the five-stage decimating CIC in the same filter library.
- Data path: comb section at the input sample rate, then a zero-stuffing upsampler, then an integrator section at the output rate.
- Accepts one input sample per burst and emits DECIMATION-style bursts of INTERP_RATE output samples, one per clock, with an input-side ready handshake.

---
 rtl/cic_int_n5.sv | 152 +++++++++++++++
 tb/tb_cic_int_n5.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_int_n5.sv
// Five-stage interpolating CIC (differential delay 2): input-rate comb, zero-stuffer, output-rate integrators.
// Optional drop counter port drop_cnt is enabled by defining CIC_INT_DROP_CNT_EN.
module cic_int_n5 #(
    parameter int INPUT_WIDTH  = 15,
    parameter int OUTPUT_WIDTH = 35,
    parameter int INTERP_RATE  = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           nd,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           rdy
`ifdef CIC_INT_DROP_CNT_EN
    ,
    output logic [7:0]                     drop_cnt
`endif
);

    localparam int        OW         = OUTPUT_WIDTH;
    localparam int        IW         = INPUT_WIDTH;
    localparam logic [7:0] LAST_PHASE = 8'(INTERP_RATE - 1);
    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] STUFF      = 1'b1;

    logic                 state_q, state_d;
    logic [7:0]           phase_q, phase_d;
    logic                 up_valid_q, up_valid_d;
    logic signed [OW-1:0] up_data_q, up_data_d;
    logic                 rdy_q;
    logic                 accept;
    logic                 last_phase;
    logic signed [OW-1:0] din_ext;

    logic signed [OW-1:0] x_q    [1:5];
    logic signed [OW-1:0] x_d1_q [1:5];
    logic signed [OW-1:0] x_dd_q [1:5];
    logic signed [OW-1:0] diff   [1:5];
    logic signed [OW-1:0] comb_out_q;
    logic signed [OW-1:0] integ_q [1:5];

    assign din_ext    = {{(OW - IW){din[IW-1]}}, din};
    assign last_phase = (phase_q == LAST_PHASE);
    assign in_ready   = (state_q == IDLE) || last_phase;
    assign accept     = nd && in_ready;

    // Delay-2 difference of each comb stage feeds the next stage.
    for (genvar gi = 1; gi <= 5; gi++) begin : g_diff
        assign diff[gi] = x_q[gi] - x_dd_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= 5; k++) begin
                x_q[k]    <= '0;
                x_d1_q[k] <= '0;
                x_dd_q[k] <= '0;
            end
            comb_out_q <= '0;
        end else if (accept) begin
            x_q[1] <= din_ext;
            for (int k = 2; k <= 5; k++) begin
                x_q[k] <= diff[k-1];
            end
            for (int k = 1; k <= 5; k++) begin
                x_d1_q[k] <= x_q[k];
                x_dd_q[k] <= x_d1_q[k];
            end
            comb_out_q <= diff[5];
        end
    end

    // Zero-stuffer: comb sample on phase 0, zeros for the remaining phases.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        up_valid_d = 1'b0;
        up_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = STUFF;
                    phase_d = '0;
                end
            end
            default: begin
                up_valid_d = 1'b1;
                if (phase_q == 8'd0) begin
                    up_data_d = comb_out_q;
                end
                if (last_phase) begin
                    phase_d = '0;
                    if (!accept) begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            up_valid_q <= 1'b0;
            up_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            up_valid_q <= up_valid_d;
            up_data_q  <= up_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= 5; k++) begin
                integ_q[k] <= '0;
            end
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= up_valid_q;
            if (up_valid_q) begin
                integ_q[1] <= integ_q[1] + up_data_q;
                for (int k = 2; k <= 5; k++) begin
                    integ_q[k] <= integ_q[k-1] + integ_q[k];
                end
            end
        end
    end

    assign dout = integ_q[5];
    assign rdy  = rdy_q;

`ifdef CIC_INT_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (nd && !in_ready && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cic_int_n5.sv
// Self-checking bench for cic_int_n5: table vectors, hand sequences and a
// convolution reference model (boxcar-24 to the fifth power, polyphase-indexed).
module tb_cic_int_n5;

    localparam int R    = 12;
    localparam int HLEN = 116;
    localparam int LAT  = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               nd;
    logic signed [14:0] din;
    logic               in_ready;
    logic signed [34:0] dout;
    logic               rdy;
`ifdef CIC_INT_DROP_CNT_EN
    logic [7:0]         drop_cnt;
`endif

    cic_int_n5 dut (
        .clk      (clk),
        .rst      (rst),
        .nd       (nd),
        .din      (din),
        .in_ready (in_ready),
        .dout     (dout),
        .rdy      (rdy)
`ifdef CIC_INT_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     passes = 0;
    int     cyc    = 0;
    int     pc     = 0;
    longint h [HLEN];
    longint x_hist [$];
    longint outs [$];
    int     out_cyc [$];
    longint imp_ref [$];

    typedef struct {
        int     idx;
        longint exp;
    } imp_vec_t;

    typedef struct {
        int   c;
        logic ir;
        logic rd;
    } hs_vec_t;

    imp_vec_t imp_tab [7];
    hs_vec_t  hs_tab [16];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Impulse response of the whole interpolator at the output rate.
    function automatic void build_h();
        longint a [HLEN];
        longint b [HLEN];
        int len = 1;
        for (int i = 0; i < HLEN; i++) a[i] = 0;
        a[0] = 1;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < HLEN; i++) begin
                b[i] = 0;
                for (int j = 0; j < 2 * R; j++)
                    if (i - j >= 0 && i - j < len) b[i] += a[i - j];
            end
            len += 2 * R - 1;
            a = b;
        end
        h = a;
    endfunction

    function automatic longint model_y(input int p);
        longint s = 0;
        logic signed [34:0] w;
        for (int k = 0; k < x_hist.size(); k++) begin
            int idx = p - LAT - R * k;
            if (idx >= 0 && idx < HLEN) s += x_hist[k] * h[idx];
        end
        w = s[34:0];
        return longint'(w);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rdy === 1'b1) begin
            chk($sformatf("dout_pulse%0d", pc), longint'(dout), model_y(pc));
            outs.push_back(longint'(dout));
            out_cyc.push_back(cyc);
            pc++;
        end
    end

    task automatic clear_model();
        x_hist.delete();
        outs.delete();
        out_cyc.delete();
        pc = 0;
    endtask

    task automatic do_reset();
        nd  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_model();
        rst = 1'b0;
    endtask

    // Holds nd high until accepted; returns at the negedge after the accepting edge.
    task automatic send(input logic signed [14:0] x);
        int guard = 0;
        din = x;
        nd  = 1'b1;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("send_timeout_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        x_hist.push_back(longint'(x));
    endtask

    task automatic run_impulse();
        for (int i = 0; i < 16; i++) send((i == 0) ? 15'sd1 : 15'sd0);
        nd = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        longint sum;
        rst = 1'b1;
        nd  = 1'b0;
        din = '0;
        build_h();

        imp_tab[0] = '{0, 0};
        imp_tab[1] = '{63, 0};
        imp_tab[2] = '{64, 1};
        imp_tab[3] = '{65, 5};
        imp_tab[4] = '{66, 15};
        imp_tab[5] = '{67, 35};
        imp_tab[6] = '{68, 70};
        for (int c = 0; c < 16; c++)
            hs_tab[c] = '{c, (c >= 11), (c >= 2 && c <= 13)};

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("reset_dout", longint'(dout), 0);
        chk("reset_rdy", longint'(rdy), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        clear_model();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_rdy", outs.size(), 0);
        chk("idle_in_ready", longint'(in_ready), 1);

        // Impulse with back-to-back accepts
        run_impulse();
        chk("impulse_pulses", outs.size(), 16 * R);
        for (int i = 0; i < 7; i++)
            if (imp_tab[i].idx < outs.size())
                chk($sformatf("impulse_idx%0d", imp_tab[i].idx), outs[imp_tab[i].idx], imp_tab[i].exp);
        sum = 0;
        foreach (outs[i]) sum += outs[i];
        chk("impulse_sum", sum, 7962624);
        if (out_cyc.size() > 0)
            chk("impulse_no_gap", out_cyc[out_cyc.size() - 1] - out_cyc[0], out_cyc.size() - 1);
        imp_ref = outs;

        // Handshake: single accept, then 10 dropped nd cycles mid-burst
        do_reset();
        send(15'sd100);
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("hs_in_ready_c%0d", hs_tab[c].c), longint'(in_ready), longint'(hs_tab[c].ir));
            chk($sformatf("hs_rdy_c%0d", hs_tab[c].c), longint'(rdy), longint'(hs_tab[c].rd));
            nd = (c >= 1 && c <= 10);
            @(negedge clk);
        end
        nd = 1'b0;
        repeat (5) @(negedge clk);
        chk("hs_pulses_per_sample", outs.size(), R);
`ifdef CIC_INT_DROP_CNT_EN
        chk("drop_cnt", longint'(drop_cnt), 10);
`endif

        // DC gain, positive and most-negative input
        do_reset();
        for (int i = 0; i < 20; i++) send(15'sd1);
        nd = 1'b0;
        repeat (20) @(negedge clk);
        chk("dc_pos_pulses", outs.size(), 20 * R);
        for (int i = 228; i < 240; i++)
            if (i < outs.size()) chk($sformatf("dc_pos_idx%0d", i), outs[i], 663552);

        do_reset();
        for (int i = 0; i < 20; i++) send(-15'sd16384);
        nd = 1'b0;
        repeat (20) @(negedge clk);
        chk("dc_neg_pulses", outs.size(), 20 * R);
        for (int i = 228; i < 240; i++)
            if (i < outs.size()) chk($sformatf("dc_neg_idx%0d", i), outs[i], -64'sd10871635968);

        // Random samples with random idle gaps, checked pulse by pulse by the monitor
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(15'($urandom));
            nd = 1'b0;
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end
        nd = 1'b0;
        repeat (20) @(negedge clk);
        chk("random_pulses", outs.size(), 40 * R);

        // Reset at phase 5, then the impulse must replay identically
        do_reset();
        send(15'sd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        nd  = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", longint'(rdy), 0);
        chk("midrst_dout", longint'(dout), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        clear_model();
        rst = 1'b0;
        run_impulse();
        chk("midrst_replay_len", outs.size(), imp_ref.size());
        for (int i = 0; i < imp_ref.size(); i++)
            if (i < outs.size()) chk($sformatf("midrst_replay_idx%0d", i), outs[i], imp_ref[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
